shift7_sched: RTL and testbench

//  Round-robin scheduler that shares one 7-bit parallel-to-serial shifter between NREQ requesters.
//  It accepts a 7-bit word from the winning requester through a valid/ready handshake.
//  It then drives the shifter's active-low load strobe and data bus, and frames the 7 serial bit times.
//  It sits between the channel sources and the shift7 serializer in the transmit path.

---
 rtl/shift7_sched_if.sv | 21 ++
 rtl/shift7_sched.sv | 187 ++++++++++++++++++
 tb/tb_shift7_sched.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift7_sched_if.sv
// Requester-side handshake bundle for shift7_sched.
// req_valid/req_data from the requesters, req_ready back as a one-hot accept.
interface shift7_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [7*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/shift7_sched.sv
// Round-robin scheduler feeding one 7-bit parallel-to-serial shifter.
// Ports: clk, rst (async active-low), req (slave handshake: req_valid,
// req_data, req_ready), sh_load_n/sh_data to the shifter, bit framing
// (sh_bit_valid, bit_idx, frame_start, frame_end), grant_id, busy.
// Option: define SHIFT7_SCHED_PRIO_EN to make requester 0 strict-priority.
module shift7_sched #(
    parameter int NREQ = 4,
    parameter int GAP  = 1,
    parameter int IDW  = 2
) (
    input  logic           clk,
    input  logic           rst,
    shift7_sched_if.slave  req,
    output logic           sh_load_n,
    output logic [6:0]     sh_data,
    output logic           sh_bit_valid,
    output logic [2:0]     bit_idx,
    output logic           frame_start,
    output logic           frame_end,
    output logic [IDW-1:0] grant_id,
    output logic           busy
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] req_ready_q, req_ready_d;
    logic            sh_load_n_q, sh_load_n_d;
    logic [6:0]      sh_data_q, sh_data_d;
    logic            sh_bit_valid_q, sh_bit_valid_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic            frame_start_q, frame_start_d;
    logic            frame_end_q, frame_end_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic            busy_q, busy_d;
    logic [IDW-1:0]  rr_last_q, rr_last_d;
    logic [3:0]      gap_cnt_q, gap_cnt_d;

    logic           any_win;
    logic [IDW-1:0] win;
    logic           upd_rr;
    logic           to_idle;

    // Winner search starts one past the last served requester.
    always_comb begin
        int idx;
        any_win = 1'b0;
        win     = '0;
        upd_rr  = 1'b1;
        idx     = 0;
`ifdef SHIFT7_SCHED_PRIO_EN
        if (req.req_valid[0]) begin
            any_win = 1'b1;
            upd_rr  = 1'b0;
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (int'(rr_last_q) + k) % NREQ;
                if (!any_win && idx != 0 && req.req_valid[idx]) begin
                    any_win = 1'b1;
                    win     = IDW'(idx);
                end
            end
        end
`else
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(rr_last_q) + k) % NREQ;
            if (!any_win && req.req_valid[idx]) begin
                any_win = 1'b1;
                win     = IDW'(idx);
            end
        end
`endif
    end

    always_comb begin
        state_d        = state_q;
        req_ready_d    = '0;
        sh_load_n_d    = 1'b1;
        sh_data_d      = sh_data_q;
        sh_bit_valid_d = 1'b0;
        bit_idx_d      = '0;
        frame_start_d  = 1'b0;
        frame_end_d    = 1'b0;
        grant_id_d     = grant_id_q;
        rr_last_d      = rr_last_q;
        gap_cnt_d      = gap_cnt_q;
        to_idle        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // A pending ready means this cycle is the accept cycle.
                if (|req_ready_q) begin
                    state_d     = S_LOAD;
                    sh_load_n_d = 1'b0;
                    sh_data_d   = req.req_data[7*int'(grant_id_q) +: 7];
                end else begin
                    to_idle = 1'b1;
                end
            end
            S_LOAD: begin
                state_d        = S_SHIFT;
                sh_bit_valid_d = 1'b1;
                frame_start_d  = 1'b1;
            end
            S_SHIFT: begin
                if (bit_idx_q == 3'd6) begin
                    if (GAP == 0) begin
                        to_idle = 1'b1;
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = 4'(GAP - 1);
                    end
                end else begin
                    sh_bit_valid_d = 1'b1;
                    bit_idx_d      = bit_idx_q + 3'd1;
                    frame_end_d    = (bit_idx_q == 3'd5);
                end
            end
            S_GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    to_idle = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Arbitrate on the way into IDLE so the accept lands in
        // the first IDLE cycle.
        if (to_idle) begin
            state_d = S_IDLE;
            if (any_win) begin
                req_ready_d = NREQ'(1) << win;
                grant_id_d  = win;
                if (upd_rr) begin
                    rr_last_d = win;
                end
            end
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            req_ready_q    <= '0;
            sh_load_n_q    <= 1'b1;
            sh_data_q      <= '0;
            sh_bit_valid_q <= 1'b0;
            bit_idx_q      <= '0;
            frame_start_q  <= 1'b0;
            frame_end_q    <= 1'b0;
            grant_id_q     <= '0;
            busy_q         <= 1'b0;
            rr_last_q      <= IDW'(NREQ - 1);
            gap_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            req_ready_q    <= req_ready_d;
            sh_load_n_q    <= sh_load_n_d;
            sh_data_q      <= sh_data_d;
            sh_bit_valid_q <= sh_bit_valid_d;
            bit_idx_q      <= bit_idx_d;
            frame_start_q  <= frame_start_d;
            frame_end_q    <= frame_end_d;
            grant_id_q     <= grant_id_d;
            busy_q         <= busy_d;
            rr_last_q      <= rr_last_d;
            gap_cnt_q      <= gap_cnt_d;
        end
    end

    assign req.req_ready = req_ready_q;
    assign sh_load_n     = sh_load_n_q;
    assign sh_data       = sh_data_q;
    assign sh_bit_valid  = sh_bit_valid_q;
    assign bit_idx       = bit_idx_q;
    assign frame_start   = frame_start_q;
    assign frame_end     = frame_end_q;
    assign grant_id      = grant_id_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_shift7_sched.sv
// Directed bench for shift7_sched: GAP=1 instance plus a GAP=0 instance.
// Requesters are assumed to hold req_valid until their accept cycle.
module tb_shift7_sched;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0;
    int n_fail = 0;

    shift7_sched_if #(.NREQ(4)) rif();
    shift7_sched_if #(.NREQ(4)) rif0();

    logic       sh_load_n, sh_bit_valid, frame_start, frame_end, busy;
    logic [6:0] sh_data;
    logic [2:0] bit_idx;
    logic [1:0] grant_id;

    logic       sh_load_n_z, sh_bit_valid_z, frame_start_z, frame_end_z, busy_z;
    logic [6:0] sh_data_z;
    logic [2:0] bit_idx_z;
    logic [1:0] grant_id_z;

    shift7_sched #(.NREQ(4), .GAP(1), .IDW(2)) u_dut (
        .clk(clk), .rst(rst), .req(rif),
        .sh_load_n(sh_load_n), .sh_data(sh_data),
        .sh_bit_valid(sh_bit_valid), .bit_idx(bit_idx),
        .frame_start(frame_start), .frame_end(frame_end),
        .grant_id(grant_id), .busy(busy)
    );

    shift7_sched #(.NREQ(4), .GAP(0), .IDW(2)) u_dut0 (
        .clk(clk), .rst(rst), .req(rif0),
        .sh_load_n(sh_load_n_z), .sh_data(sh_data_z),
        .sh_bit_valid(sh_bit_valid_z), .bit_idx(bit_idx_z),
        .frame_start(frame_start_z), .frame_end(frame_end_z),
        .grant_id(grant_id_z), .busy(busy_z)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    task automatic find_accept(input int sel, input int budget,
                               output int at, output logic [3:0] rdy);
        at  = -1;
        rdy = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            rdy = (sel == 0) ? rif.req_ready : rif0.req_ready;
            if (rdy != 4'b0) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rif.req_valid = '0;
        rif.req_data = '0;
        rif0.req_valid = '0;
        rif0.req_data = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({sh_load_n, sh_bit_valid, frame_start, frame_end, busy} !== 5'b10000) begin
            n_fail++;
            $display("FAIL rst_strobes: got %b expected 10000",
                     {sh_load_n, sh_bit_valid, frame_start, frame_end, busy});
        end
        n_chk++;
        if ({sh_data, bit_idx, grant_id} !== 12'h0) begin
            n_fail++;
            $display("FAIL rst_buses: got %h expected 000", {sh_data, bit_idx, grant_id});
        end
        n_chk++;
        if (rif.req_ready !== 4'b0) begin
            n_fail++;
            $display("FAIL rst_ready: got %b expected 0000", rif.req_ready);
        end
        n_chk++;
        if ({sh_load_n_z, busy_z, rif0.req_ready} !== 6'b100000) begin
            n_fail++;
            $display("FAIL rst_dut0: got %b expected 100000",
                     {sh_load_n_z, busy_z, rif0.req_ready});
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({busy, rif.req_ready} !== 5'b0) begin
            n_fail++;
            $display("FAIL idle_no_req: got %b expected 00000", {busy, rif.req_ready});
        end
    endtask

    task automatic test_single();
        int t;
        logic [3:0] r;
        logic [6:0] ser;
        ser = 7'b1010101;
        rif.req_data[6:0] = 7'h55;
        rif.req_valid = 4'b0001;
        find_accept(0, 5, t, r);
        n_chk++;
        if (t < 0 || r !== 4'b0001 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_accept: got %b busy %b expected 0001 busy 0", r, busy);
        end
        @(negedge clk);
        rif.req_valid = '0;
        n_chk++;
        if (sh_load_n !== 1'b0 || sh_data !== 7'h55 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_load: got load_n %b data %h expected 0 55", sh_load_n, sh_data);
        end
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            n_chk++;
            if ({sh_load_n, sh_bit_valid, bit_idx, frame_start, frame_end} !==
                {1'b1, 1'b1, 3'(i), (i == 0), (i == 6)}) begin
                n_fail++;
                $display("FAIL single_bit%0d: got %b expected %b", i,
                         {sh_load_n, sh_bit_valid, bit_idx, frame_start, frame_end},
                         {1'b1, 1'b1, 3'(i), (i == 0), (i == 6)});
            end
            n_chk++;
            if (sh_data[bit_idx] !== ser[i]) begin
                n_fail++;
                $display("FAIL single_serial%0d: got %b expected %b", i, sh_data[bit_idx], ser[i]);
            end
        end
        @(negedge clk);
        n_chk++;
        if (sh_bit_valid !== 1'b0 || busy !== 1'b1 || rif.req_ready !== 4'b0) begin
            n_fail++;
            $display("FAIL single_gap: got bv %b busy %b expected 0 1", sh_bit_valid, busy);
        end
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: got busy %b expected 0", busy);
        end
    endtask

    task automatic run_seq(input string nm, input int n, input int exp[8],
                           input int drop_after, input int spacing);
        int t, prev;
        logic [3:0] r;
        logic [6:0] wv [4];
        wv = '{7'h11, 7'h22, 7'h33, 7'h44};
        prev = -1;
        for (int k = 0; k < n; k++) begin
            find_accept(0, 25, t, r);
            n_chk++;
            if (t < 0 || r !== (4'b0001 << exp[k]) || grant_id !== 2'(exp[k])) begin
                n_fail++;
                $display("FAIL %s_grant%0d: got ready %b id %0d expected id %0d",
                         nm, k, r, grant_id, exp[k]);
            end
            n_chk++;
            if ((r & ~rif.req_valid) !== 4'b0) begin
                n_fail++;
                $display("FAIL %s_ready_vs_valid%0d: got %b valid %b expected subset",
                         nm, k, r, rif.req_valid);
            end
            if (k > 0 && spacing > 0) begin
                n_chk++;
                if (t - prev !== spacing) begin
                    n_fail++;
                    $display("FAIL %s_spacing%0d: got %0d expected %0d",
                             nm, k, t - prev, spacing);
                end
            end
            prev = t;
            @(negedge clk);
            if (k == drop_after) rif.req_valid[0] = 1'b0;
            n_chk++;
            if (sh_data !== wv[exp[k]]) begin
                n_fail++;
                $display("FAIL %s_data%0d: got %h expected %h", nm, k, sh_data, wv[exp[k]]);
            end
        end
        rif.req_valid = '0;
        repeat (12) @(negedge clk);
    endtask

    task automatic load_words();
        rif.req_data = {7'h44, 7'h33, 7'h22, 7'h11};
    endtask

    task automatic test_rr_all();
        int exp[8];
        exp = '{0, 1, 2, 3, 0, 0, 0, 0};
        apply_reset();
        load_words();
        rif.req_valid = 4'b1111;
        run_seq("rr_all", 5, exp, -1, 10);
    endtask

    task automatic test_prio();
        int exp[8];
        exp = '{0, 0, 0, 1, 2, 3, 1, 0};
        apply_reset();
        load_words();
        rif.req_valid = 4'b1111;
        run_seq("prio", 7, exp, 2, 10);
    endtask

    task automatic test_skip();
        int exp[8];
        exp = '{1, 3, 1, 3, 0, 0, 0, 0};
        load_words();
        rif.req_valid = 4'b0010;
        @(posedge clk);
        #1;
        rif.req_valid = 4'b1010;
        run_seq("skip", 4, exp, -1, 10);
    endtask

    task automatic test_mid_reset();
        int t;
        logic [3:0] r;
        load_words();
        rif.req_valid = 4'b0001;
        find_accept(0, 25, t, r);
        rif.req_valid = 4'b0101;
        n_chk++;
        if (t < 0 || r !== 4'b0001) begin
            n_fail++;
            $display("FAIL mid_first: got %b expected 0001", r);
        end
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        n_chk++;
        if (busy !== 1'b1 || sh_bit_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_inframe: got busy %b bv %b expected 1 1", busy, sh_bit_valid);
        end
        rst = 1'b0;
        #1;
        n_chk++;
        if ({sh_load_n, sh_bit_valid, frame_start, frame_end, busy, sh_data,
             bit_idx, grant_id, rif.req_ready} !== {5'b10000, 16'h0}) begin
            n_fail++;
            $display("FAIL mid_async: got %h expected %h",
                     {sh_load_n, sh_bit_valid, frame_start, frame_end, busy, sh_data,
                      bit_idx, grant_id, rif.req_ready}, {5'b10000, 16'h0});
        end
        @(negedge clk);
        rst = 1'b1;
        find_accept(0, 25, t, r);
        n_chk++;
        if (t < 0 || r !== 4'b0001 || grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_restart: got %b id %0d expected 0001 id 0", r, grant_id);
        end
        @(negedge clk);
        rif.req_valid = '0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int t, prev;
        logic [3:0] r;
        rif0.req_data[6:0] = 7'h2a;
        rif0.req_valid = 4'b0001;
        prev = -1;
        for (int k = 0; k < 3; k++) begin
            find_accept(1, 25, t, r);
            n_chk++;
            if (t < 0 || r !== 4'b0001 || busy_z !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_accept%0d: got %b busy %b expected 0001 0", k, r, busy_z);
            end
            if (k > 0) begin
                n_chk++;
                if (t - prev !== 9) begin
                    n_fail++;
                    $display("FAIL b2b_spacing%0d: got %0d expected 9", k, t - prev);
                end
            end
            prev = t;
            @(negedge clk);
            n_chk++;
            if (sh_load_n_z !== 1'b0 || sh_data_z !== 7'h2a) begin
                n_fail++;
                $display("FAIL b2b_load%0d: got %b %h expected 0 2a", k, sh_load_n_z, sh_data_z);
            end
            repeat (7) @(negedge clk);
            n_chk++;
            if (frame_end_z !== 1'b1 || bit_idx_z !== 3'd6 || sh_bit_valid_z !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_end%0d: got fe %b idx %0d expected 1 6", k, frame_end_z, bit_idx_z);
            end
        end
        rif0.req_valid = '0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
`ifdef SHIFT7_SCHED_PRIO_EN
        test_prio();
`else
        test_rr_all();
`endif
        test_skip();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
